// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the program loader and its address counter.
package definitions;

    // Loader sequencing states:
    //   S_IDLE  | waiting for the first beat of a new load
    //   S_LD_IM | streaming words into instruction memory
    //   S_LD_DM | streaming bytes into data memory
    //   S_RST   | holding the core in reset before the run
    //   S_RUN   | core running, counting cycles until done or timeout
    //   S_DUMP  | core frozen, data memory window streamed out
    //   S_FIN   | one-cycle wrap-up with status held, then back to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_IM,
        S_LD_DM,
        S_RST,
        S_RUN,
        S_DUMP,
        S_FIN
    } loader_state_t;

    localparam int kIM_W   = 9;
    localparam int kDM_W   = 8;
    localparam int kADDR_W = 8;

endpackage

// File: rtl/prog_loader_counter.sv
// Address/index counter: 8-bit address out, one extra internal bit so a
// full 256-entry memory can be reported as "at limit" instead of wrapping.
module ld_counter
    import definitions::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [kADDR_W:0]   limit,
    output logic [kADDR_W-1:0] count,
    output logic               at_limit
);

    logic [kADDR_W:0] cnt;

    // Clear wins over enable; the count holds once it reaches the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign count    = cnt[kADDR_W-1:0];
    assign at_limit = (cnt == limit);

endmodule

// File: rtl/prog_loader.sv
// Program loader: writes instruction/data images from a stream, runs the
// core until done or timeout, then streams a window of data memory back.
module prog_loader
    import definitions::*;
#(
    parameter int          IM_DEPTH  = 256,
    parameter int          DM_DEPTH  = 256,
    parameter int          RST_CYC   = 2,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF,
    parameter logic [7:0]  DUMP_BASE = 8'd0,
    parameter logic [7:0]  DUMP_LEN  = 8'd16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [kIM_W-1:0]   in_data,
    input  logic               in_last,
    output logic               im_we,
    output logic [kADDR_W-1:0] im_addr,
    output logic [kIM_W-1:0]   im_din,
    output logic               dm_we,
    output logic [kADDR_W-1:0] dm_addr,
    output logic [kDM_W-1:0]   dm_din,
    input  logic [kDM_W-1:0]   dm_dout,
    output logic               cpu_rst,
    input  logic               cpu_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [kDM_W-1:0]   out_data,
    output logic               out_last,
    output logic [15:0]        run_cycles,
    output logic               busy,
    output logic               timed_out,
    output logic               ovf
);

    localparam logic [15:0]        kRunMax  = TIMEOUT - 16'd1;
    localparam logic [7:0]         kRstLast = 8'(RST_CYC - 1);
    // DUMP_LEN of 0 means a full 256-byte window; the dump counter
    // saturates on the final index, so its at_limit doubles as out_last.
    localparam logic [kADDR_W:0]   kDumpLastIdx =
        (DUMP_LEN == 8'd0) ? 9'd255 : 9'(DUMP_LEN) - 9'd1;

    loader_state_t      state;
    logic [7:0]         rst_cnt;
    logic               in_hs;
    logic               out_hs;
    logic               loading_im;
    logic               loading_dm;
    logic [kADDR_W-1:0] ld_addr;
    logic               ld_full;
    logic               ld_clr;
    logic [kADDR_W:0]   ld_limit;
    logic [kADDR_W-1:0] dump_idx;
    logic               dump_last;

    assign in_hs      = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    // The first beat in IDLE is instruction word 0, so IDLE loads like LD_IM.
    assign loading_im = (state == S_IDLE) || (state == S_LD_IM);
    assign loading_dm = (state == S_LD_DM);

    assign ld_limit = loading_dm ? 9'(DM_DEPTH) : 9'(IM_DEPTH);
    assign ld_clr   = !(loading_im || loading_dm) || (in_hs && in_last && loading_im);

    ld_counter u_ld_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (ld_clr),
        .en       (in_hs && (loading_im || loading_dm)),
        .limit    (ld_limit),
        .count    (ld_addr),
        .at_limit (ld_full)
    );

    ld_counter u_dump_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (state != S_DUMP),
        .en       (out_hs),
        .limit    (kDumpLastIdx),
        .count    (dump_idx),
        .at_limit (dump_last)
    );

    // Memory write strobes follow the handshake directly; beats past the
    // memory depth are swallowed without a write.
    always_comb begin
        im_we   = in_hs && loading_im && !ld_full;
        im_addr = ld_addr;
        im_din  = in_data;
        dm_we   = in_hs && loading_dm && !ld_full;
        dm_din  = in_data[kDM_W-1:0];
        dm_addr = ld_addr;
        if (state == S_DUMP) begin
            dm_addr = DUMP_BASE + dump_idx;
        end
        out_data = dm_dout;
        out_last = (state == S_DUMP) && dump_last;
    end

    // Sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            in_ready   <= 1'b1;
            cpu_rst    <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            run_cycles <= '0;
            timed_out  <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_hs) begin
                        run_cycles <= '0;
                        timed_out  <= 1'b0;
                        ovf        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= in_last ? S_LD_DM : S_LD_IM;
                    end
                end
                S_LD_IM: begin
                    if (in_hs) begin
                        if (ld_full) ovf <= 1'b1;
                        if (in_last) state <= S_LD_DM;
                    end
                end
                S_LD_DM: begin
                    if (in_hs) begin
                        if (ld_full) ovf <= 1'b1;
                        if (in_last) begin
                            state    <= S_RST;
                            in_ready <= 1'b0;
                            rst_cnt  <= '0;
                        end
                    end
                end
                S_RST: begin
                    if (rst_cnt == kRstLast) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    // done has priority over a coincident timeout
                    if (cpu_done || (run_cycles == kRunMax)) begin
                        state     <= S_DUMP;
                        cpu_rst   <= 1'b1;
                        out_valid <= 1'b1;
                        if (!cpu_done) timed_out <= 1'b1;
                    end else begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                end
                S_DUMP: begin
                    if (out_hs && dump_last) begin
                        state     <= S_FIN;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                S_FIN: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
